// File: rtl/fwd_hazard_unit_n_if.sv
// Bundle between the ID stage and the forwarding/hazard unit.
// The master drives register sources and producer stage state; the slave returns forwards and stalls.
interface fwd_hazard_unit_n_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 2
);
    logic                        pipe_ready;
    logic [NUM_SRC*REG_AW-1:0]   src_addr;
    logic [NUM_SRC-1:0]          src_used;
    logic                        bj_use;
    logic [NUM_STG-1:0]          stg_wen;
    logic [NUM_STG*REG_AW-1:0]   stg_dst;
    logic [NUM_STG-1:0]          stg_rdy;
    logic [NUM_STG*DATA_W-1:0]   stg_data;
    logic                        stall;
    logic                        bj_ok;
    logic [NUM_SRC-1:0]          fwd_valid;
    logic [NUM_SRC-1:0]          fwd_bj;
    logic [NUM_SRC*DATA_W-1:0]   fwd_data;

    modport master (
        output pipe_ready, src_addr, src_used, bj_use, stg_wen, stg_dst, stg_rdy, stg_data,
        input  stall, bj_ok, fwd_valid, fwd_bj, fwd_data
    );

    modport slave (
        input  pipe_ready, src_addr, src_used, bj_use, stg_wen, stg_dst, stg_rdy, stg_data,
        output stall, bj_ok, fwd_valid, fwd_bj, fwd_data
    );
endinterface

// File: rtl/fwd_hazard_unit_n.sv
// ID-stage forwarding and hazard unit: NUM_SRC sources against NUM_STG producer stages.
// Optional stall/hold counters are built when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_unit_n #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 2
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef FWD_HAZARD_PERF_EN
    output logic [31:0]          perf_ld_stalls,
    output logic [31:0]          perf_bj_holds,
`endif
    fwd_hazard_unit_n_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } bj_state_t;

    bj_state_t                  state_reg;
    bj_state_t                  state_next;

    logic [NUM_SRC-1:0]         hit;
    logic [NUM_SRC-1:0]         rdy_hit;
    logic [NUM_SRC-1:0]         ld_haz;
    logic [NUM_SRC*DATA_W-1:0]  fwd_data_next;
    logic [NUM_SRC-1:0]         fwd_valid_reg;
    logic [NUM_SRC-1:0]         fwd_bj_reg;
    logic [NUM_SRC*DATA_W-1:0]  fwd_data_reg;
    logic                       stall;
    logic                       bj_haz;
    logic                       bj_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic              win_hit;
            logic              win_rdy;
            logic [DATA_W-1:0] win_data;
            logic [REG_AW-1:0] src_reg;

            assign src_reg = bus.src_addr[gi*REG_AW +: REG_AW];

            // Walk from the oldest stage to the youngest so a younger match overrides.
            always_comb begin
                win_hit  = 1'b0;
                win_rdy  = 1'b0;
                win_data = '0;
                for (int k = NUM_STG - 1; k >= 0; k--) begin
                    if (bus.src_used[gi] && bus.stg_wen[k] &&
                        (bus.stg_dst[k*REG_AW +: REG_AW] != '0) &&
                        (bus.stg_dst[k*REG_AW +: REG_AW] == src_reg)) begin
                        win_hit  = 1'b1;
                        win_rdy  = bus.stg_rdy[k];
                        win_data = bus.stg_data[k*DATA_W +: DATA_W];
                    end
                end
            end

            assign hit[gi]     = win_hit;
            assign rdy_hit[gi] = win_hit & win_rdy;
            assign ld_haz[gi]  = win_hit & ~win_rdy;
            assign fwd_data_next[gi*DATA_W +: DATA_W] = (win_hit & win_rdy) ? win_data : '0;
        end
    endgenerate

    assign stall  = |ld_haz;
    assign bj_haz = bus.bj_use & (|hit);

    always_comb begin
        state_next = state_reg;
        bj_ok      = 1'b1;
        case (state_reg)
            IDLE: begin
                bj_ok = ~bj_haz;
                // A load-use stall keeps us here; the branch re-evaluates once the load lands.
                if (bus.pipe_ready && bj_haz && !stall) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                bj_ok = 1'b1;
                if (bus.pipe_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            fwd_valid_reg <= '0;
            fwd_bj_reg    <= '0;
            fwd_data_reg  <= '0;
        end else if (bus.pipe_ready) begin
            state_reg     <= state_next;
            fwd_valid_reg <= rdy_hit;
            fwd_bj_reg    <= rdy_hit & {NUM_SRC{bus.bj_use}};
            fwd_data_reg  <= fwd_data_next;
        end
    end

    assign bus.stall     = stall;
    assign bus.bj_ok     = bj_ok;
    assign bus.fwd_valid = fwd_valid_reg;
    assign bus.fwd_bj    = fwd_bj_reg;
    assign bus.fwd_data  = fwd_data_reg;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_ld_reg;
    logic [31:0] perf_bj_reg;
    logic        bj_enter;

    assign bj_enter = bus.pipe_ready && (state_reg == IDLE) && (state_next == HOLD);

    // Saturating counters: once at all-ones they stay there.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ld_reg <= '0;
            perf_bj_reg <= '0;
        end else begin
            if (bus.pipe_ready && stall && (perf_ld_reg != 32'hFFFF_FFFF)) begin
                perf_ld_reg <= perf_ld_reg + 32'd1;
            end
            if (bj_enter && (perf_bj_reg != 32'hFFFF_FFFF)) begin
                perf_bj_reg <= perf_bj_reg + 32'd1;
            end
        end
    end

    assign perf_ld_stalls = perf_ld_reg;
    assign perf_bj_holds  = perf_bj_reg;
`endif

endmodule

// File: doc/fwd_hazard_unit_n.md
Name: fwd_hazard_unit_n

Overview:
- Parametrised forwarding and hazard unit for the ID stage. It is the generalised successor of the two-source, two-stage forwarding logic.
- Serves NUM_SRC register read sources against NUM_STG downstream producer stages, with a per-stage result-ready flag.
- Detects load-use (producer not yet ready) stalls and sequences the one-cycle wait that branch/jr operands need.
- Forwarded data and select flags are registered into the next cycle, under control of the pipeline-advance signal.

Parameters:
- DATA_W, 32, forwarded data width.
- REG_AW, 5, register address width; address 0 is hardwired zero and never forwarded.
- NUM_SRC, 2, number of consumer read sources (rs, rt, ...).
- NUM_STG, 2, number of producer stages; index 0 is the youngest (EX) and higher indices are older (MEM, WB...).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pipe_ready  in  1  pipeline advance enable; registered state updates only when this is 1.
- src_addr  in  NUM_SRC*REG_AW  source register numbers; source i is at bits [i*REG_AW +: REG_AW].
- src_used  in  NUM_SRC  source i is actually read by the ID instruction.
- bj_use  in  1  the ID instruction is a branch or jr (operand consumed in ID).
- stg_wen  in  NUM_STG  stage k writes a register.
- stg_dst  in  NUM_STG*REG_AW  destination register of stage k.
- stg_rdy  in  NUM_STG  result of stage k is valid now (0 for a load still in EX).
- stg_data  in  NUM_STG*DATA_W  result of stage k.
- stall  out  1  combinational load-use stall request.
- bj_ok  out  1  combinational; the branch/jr may resolve this cycle.
- fwd_valid  out  NUM_SRC  registered; use fwd_data for source i.
- fwd_bj  out  NUM_SRC  registered; the forward of source i feeds a branch/jr.
- fwd_data  out  NUM_SRC*DATA_W  registered forwarded values.

Behaviour:
- Match definition: match[i][k] = src_used[i] & stg_wen[k] & (stg_dst[k]!=0) & (stg_dst[k]==src_addr[i]).
- Priority: for each source, the lowest matching k wins (youngest producer); older matches are ignored.
- hit[i] = any match for source i.
- rdy_hit[i] = hit[i] & stg_rdy[winning k].
- ld_haz[i] = hit[i] & ~stg_rdy[winning k].
- A not-ready youngest match stalls even if an older stage also matches and is ready.
- stall = OR of ld_haz[i] over all sources. It is purely combinational, with zero latency.
- Registered update, on a clk edge with reset=0 and pipe_ready=1:
  - fwd_valid[i] <= rdy_hit[i].
  - fwd_bj[i] <= rdy_hit[i] & bj_use.
  - fwd_data[i] <= stg_data[winning k] if rdy_hit[i], else 0.
- With pipe_ready=0, all registers hold their values.
- Reset values: fwd_valid=0, fwd_bj=0, fwd_data=0, FSM=IDLE.
- Branch FSM, states IDLE and HOLD:
  - bj_haz = bj_use & (OR of hit[i]).
  - IDLE: bj_ok = ~bj_haz. If pipe_ready & bj_haz & ~stall, go to HOLD. Otherwise stay in IDLE; a load-use stall keeps the FSM in IDLE.
  - HOLD: bj_ok = 1, and the branch consumes fwd_data. On pipe_ready, go to IDLE unconditionally (no back-to-back HOLD). With pipe_ready=0, stay in HOLD.
- Simultaneous events: stall takes precedence over the FSM entering HOLD. Reset while in HOLD returns the FSM to IDLE on the next edge.
- No bj_use: bj_ok=1 in IDLE.
- Width rules: equality compares are REG_AW bits. Priority selection is a generate loop from k=NUM_STG-1 down to 0, so that the lowest index overrides.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- When defined, adds two outputs, perf_ld_stalls[31:0] and perf_bj_holds[31:0], both reset to 0.
  - perf_ld_stalls increments on every edge with pipe_ready & stall.
  - perf_bj_holds increments on every IDLE->HOLD transition.
  - Both counters saturate at 32'hFFFFFFFF and do not wrap.
- When not defined, neither the ports nor the logic exist.

Test Plan:
- Default parameters. src_addr rs=3 and rt=0 (used 2'b11); stage0 wen, dst=3, rdy=1, data=32'hA5A5_0001; pipe_ready=1 -> next cycle fwd_valid=2'b01, fwd_data[31:0]=32'hA5A5_0001, stall=0. The rt source never forwards from r0.
- Stage0 dst=7 with rdy=1 and data=1, and stage1 dst=7 with data=2; rs=7 -> fwd_data=1 (youngest wins).
- Stage0 dst=7 with rdy=0 (load), and stage1 dst=7 with rdy=1; rs=7 -> stall=1 the same cycle and fwd_valid[0]=0 next cycle. Then stage0 is cleared and stage1 presents dst=7, rdy=1, data=9 -> stall=0 and fwd_data=9.
- bj_use=1, rs=4, stage1 dst=4 ready with data=0x10 -> bj_ok=0 in cycle 0. Cycle 1: HOLD, bj_ok=1, fwd_bj=2'b01, fwd_data=0x10. Cycle 2: IDLE.
- Enter HOLD with pipe_ready held at 0 for 3 cycles -> the FSM stays in HOLD and the registers hold. Assert reset while in HOLD -> next cycle IDLE and all outputs 0.
- Set NUM_SRC=3, NUM_STG=3, with a match only at stage2 for source 2 -> fwd_valid=3'b100. With FWD_HAZARD_PERF_EN defined, 5 stall cycles -> perf_ld_stalls=5.
